// File: rtl/systolic_skew_feeder_if.sv
// Operand stream from the producer into the skew feeder: one A row-vector and one
// B column-vector per beat over valid/ready, with a last marker.
interface systolic_skew_feeder_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) ();
    logic              s_valid_i;
    logic              s_ready_o;
    logic              s_last_i;
    logic [N*DW-1:0]   s_a_i;
    logic [N*DW-1:0]   s_b_i;

    // Producer side
    modport master (
        output s_valid_i,
        output s_last_i,
        output s_a_i,
        output s_b_i,
        input  s_ready_o
    );

    // Feeder side
    modport slave (
        input  s_valid_i,
        input  s_last_i,
        input  s_a_i,
        input  s_b_i,
        output s_ready_o
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an N x N systolic MAC array.
// Accepts one A/B operand beat per cycle and drives the west/north array edges with
// a diagonal skew (lane r delayed r cycles). Bubbles are zero-filled. After the last
// beat the feeder stops accepting until the last beat reaches lane N-1, where done_o
// pulses.
// Optional build macro SKEW_FEEDER_CNT_EN adds beat_cnt_o, a 16-bit count of
// accepted beats cleared by done_o.
module systolic_skew_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    systolic_skew_feeder_if.slave   s,
    output logic [N*DW-1:0]         a_o,
    output logic [N*DW-1:0]         b_o,
    output logic [N-1:0]            lane_vld_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef SKEW_FEEDER_CNT_EN
    ,
    output logic [15:0]             beat_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    logic            ready_q;
    logic            accept_c;

    assign accept_c    = s.s_valid_i && ready_q;
    assign s.s_ready_o = ready_q;

    // Sequencer: tracks the stream, blocks input while the skew drains, pulses done.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            ready_q   <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (accept_c) begin
                        if (s.s_last_i) begin
                            if (N == 1) begin
                                // Single lane: the last beat is already on lane N-1.
                                state   <= ST_IDLE;
                                done_o  <= 1'b1;
                                busy_o  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                state     <= ST_FLUSH;
                                flush_cnt <= CW'(N - 1);
                                busy_o    <= 1'b1;
                                ready_q   <= 1'b0;
                            end
                        end else begin
                            state   <= ST_STREAM;
                            busy_o  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == CW'(1)) begin
                        state   <= ST_IDLE;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy_o  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Per-lane skew: lane r is an (r+1)-deep shift register that moves every cycle.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [DW-1:0] a_sr [0:r];
        logic [DW-1:0] b_sr [0:r];
        logic          v_sr [0:r];

        // Stage 0 takes the accepted operands or zeros; later stages just shift.
        always_ff @(posedge clock_i or negedge resetn_i) begin
            if (!resetn_i) begin
                for (int i = 0; i <= r; i++) begin
                    a_sr[i] <= '0;
                    b_sr[i] <= '0;
                    v_sr[i] <= 1'b0;
                end
            end else begin
                a_sr[0] <= accept_c ? s.s_a_i[r*DW +: DW] : '0;
                b_sr[0] <= accept_c ? s.s_b_i[r*DW +: DW] : '0;
                v_sr[0] <= accept_c;
                for (int i = 1; i <= r; i++) begin
                    a_sr[i] <= a_sr[i-1];
                    b_sr[i] <= b_sr[i-1];
                    v_sr[i] <= v_sr[i-1];
                end
            end
        end

        assign a_o[r*DW +: DW] = a_sr[r];
        assign b_o[r*DW +: DW] = b_sr[r];
        assign lane_vld_o[r]   = v_sr[r];
    end

`ifdef SKEW_FEEDER_CNT_EN
    // Accepted-beat counter; done clears it and takes priority over a same-cycle accept.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            beat_cnt_o <= '0;
        end else if (done_o) begin
            beat_cnt_o <= '0;
        end else if (accept_c) begin
            beat_cnt_o <= beat_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4, DW=8): directed scenarios plus
// random traffic, compared every cycle against a beat-history model.
module tb_systolic_skew_feeder;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = N * DW;

    typedef struct {
        logic          vld;
        logic          last;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [LW-1:0] a_o;
    logic [LW-1:0] b_o;
    logic [N-1:0]  lane_vld_o;
    logic          busy_o;
    logic          done_o;
`ifdef SKEW_FEEDER_CNT_EN
    logic [15:0]   beat_cnt_o;
    logic [15:0]   m_cnt;
`endif

    systolic_skew_feeder_if #(.N(N), .DW(DW)) sif ();

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .clock_i    (clk),
        .resetn_i   (rst_n),
        .s          (sif),
        .a_o        (a_o),
        .b_o        (b_o),
        .lane_vld_o (lane_vld_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef SKEW_FEEDER_CNT_EN
        ,
        .beat_cnt_o (beat_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: hist[d] is the stage-0 beat captured d edges ago (zero beat if nothing accepted).
    beat_t hist [N];
    logic  in_stream;
    int    n_vec;
    int    n_err;

    function automatic beat_t zero_beat();
        beat_t z;
        z.vld  = 1'b0;
        z.last = 1'b0;
        z.a    = '0;
        z.b    = '0;
        return z;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) hist[i] = zero_beat();
        in_stream = 1'b0;
`ifdef SKEW_FEEDER_CNT_EN
        m_cnt = '0;
`endif
    endfunction

    // Input is blocked while a last beat is still travelling toward lane N-1.
    function automatic logic model_ready();
        logic rdy;
        rdy = 1'b1;
        for (int j = 0; j + 1 < N; j++)
            if (hist[j].vld && hist[j].last) rdy = 1'b0;
        return rdy;
    endfunction

    function automatic logic model_done();
        return hist[N-1].vld && hist[N-1].last;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [LW-1:0] ea;
        logic [LW-1:0] eb;
        logic [N-1:0]  ev;
        for (int r = 0; r < N; r++) begin
            ea[r*DW +: DW] = hist[r].a[r*DW +: DW];
            eb[r*DW +: DW] = hist[r].b[r*DW +: DW];
            ev[r]          = hist[r].vld;
        end
        chk("a_o",        64'(a_o),          64'(ea));
        chk("b_o",        64'(b_o),          64'(eb));
        chk("lane_vld_o", 64'(lane_vld_o),   64'(ev));
        chk("done_o",     64'(done_o),       64'(model_done()));
        chk("s_ready_o",  64'(sif.s_ready_o), 64'(model_ready()));
        chk("busy_o",     64'(busy_o),       64'(in_stream || !model_ready()));
`ifdef SKEW_FEEDER_CNT_EN
        chk("beat_cnt_o", 64'(beat_cnt_o),   64'(m_cnt));
`endif
    endtask

    // One clock: present inputs, advance model across the edge, check #1 later.
    task automatic step(input logic v, input logic l, input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic  acc;
        logic  dn;
        beat_t nb;
        sif.s_valid_i = v;
        sif.s_last_i  = l;
        sif.s_a_i     = a;
        sif.s_b_i     = b;
        acc = v && model_ready();
        dn  = model_done();
        nb  = zero_beat();
        if (acc) begin
            nb.vld  = 1'b1;
            nb.last = l;
            nb.a    = a;
            nb.b    = b;
        end
        @(posedge clk);
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = nb;
        if (acc) in_stream = !l;
`ifdef SKEW_FEEDER_CNT_EN
        if (dn) m_cnt = '0;
        else if (acc) m_cnt = m_cnt + 16'd1;
`else
        if (dn && acc) in_stream = !l;
`endif
        #1;
        check_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, LW'($urandom()), LW'($urandom()));
    endtask

    initial begin
        logic [DW-1:0] v8;
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Reset with unknown inputs: outputs zero, ready high, not busy.
        rst_n         = 1'b1;
        sif.s_valid_i = 1'bx;
        sif.s_last_i  = 1'bx;
        sif.s_a_i     = 'x;
        sif.s_b_i     = 'x;
        #2 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        sif.s_valid_i = 1'b0;
        sif.s_last_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_all();

        // Four contiguous beats 0x11..0x44, last on the fourth, then drain.
        for (int i = 1; i <= 4; i++) begin
            v8 = DW'(i * 8'h11);
            step(1'b1, i == 4, {N{v8}}, ~{N{v8}});
        end
        idle(N + 1);

        // Bubble: valid 1,0,1 with last on the final beat.
        step(1'b1, 1'b0, 32'hA3A2A1A0, 32'hB3B2B1B0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
        step(1'b1, 1'b1, 32'hC3C2C1C0, 32'hD3D2D1D0);
        idle(N + 1);

        // Backpressure: keep valid high through the flush; next beat lands in the done cycle.
        step(1'b1, 1'b0, 32'h01020304, 32'h05060708);
        step(1'b1, 1'b1, 32'h11121314, 32'h15161718);
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, LW'(32'h50607080 + i), LW'(32'h90A0B0C0 + i));
        step(1'b1, 1'b1, 32'h77665544, 32'h33221100);
        idle(N + 1);

        // Mid-stream reset after two beats: immediate zeroing, no done afterwards.
        step(1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0);
        step(1'b1, 1'b0, 32'h0F1E2D3C, 32'h4B5A6978);
        #2 rst_n = 1'b0;
        sif.s_valid_i = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(N + 2);

        // Random traffic with bubbles, stray last flags and held valid.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 LW'($urandom()), LW'($urandom()));
        step(1'b1, 1'b1, LW'($urandom()), LW'($urandom()));
        idle(2 * N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
